ddr_app_arbiter: RTL and testbench

- Two-requester round-robin arbiter in front of the DDR3 controller user ("app_*") interface, in the clk_x1 domain.
- Lets two clients share one DDR3 IP instance, for example the memory tester and a future frame/DMA client.
- Serialises whole burst transactions: write data beats first, then the command.
- Routes returning read data to the requester that issued the read, using an in-order tag FIFO.

---
 rtl/ddr_app_pkg.sv | 18 +
 rtl/ddr_tag_fifo.sv | 61 ++++++
 rtl/ddr_app_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ddr_app_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// rtl/ddr_app_pkg.sv - shared encodings and types for the DDR app-interface arbiter
// Purpose: command encodings, grant FSM state constants and the read-tag record.
package ddr_app_pkg;

    localparam logic [2:0] WR_CMD = 3'h0;
    localparam logic [2:0] RD_CMD = 3'h1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] CMD   = 2'd2;

    // One outstanding read: which port issued it and how many beats (minus one) return.
    typedef struct packed {
        logic       port;
        logic [5:0] burst;
    } tag_t;

endpackage

// File: rtl/ddr_tag_fifo.sv
// rtl/ddr_tag_fifo.sv - in-order FIFO of outstanding read tags
// Purpose: remembers the issuing port and burst length of every read in flight.
// Ports: clk/rst (async active-high), push/din write side, pop/head read side,
//        full/empty occupancy flags. Push and pop in one cycle are both honoured.
module ddr_tag_fifo
    import ddr_app_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    tag_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ddr_app_arbiter.sv
// rtl/ddr_app_arbiter.sv - two-port round-robin arbiter for the DDR3 app interface
// Purpose: serialises whole bursts from two requesters (write beats, then command)
//          and routes returning read beats back to the issuing port in order.
// Ports: pN_* requester side (req/cmd/addr/burst/wdata in; wdata_ack, gnt, rdata* out),
//        app_* controller side, init_calib_complete gate, err sticky protocol error.
module ddr_app_arbiter
    import ddr_app_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk_x1,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic                  p0_req,
    input  logic [2:0]            p0_cmd,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [5:0]            p0_burst,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_wdata_ack,
    output logic                  p0_gnt,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rdata_valid,
    output logic                  p0_rdata_end,
    input  logic                  p1_req,
    input  logic [2:0]            p1_cmd,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [5:0]            p1_burst,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_wdata_ack,
    output logic                  p1_gnt,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rdata_valid,
    output logic                  p1_rdata_end,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic                  app_cmd_en,
    output logic [2:0]            app_cmd,
    input  logic                  app_cmd_rdy,
    output logic                  app_wren,
    output logic                  app_data_end,
    output logic [DATA_WIDTH-1:0] app_data,
    input  logic                  app_data_rdy,
    output logic [5:0]            app_burst_number,
    input  logic                  app_rdata_valid,
    input  logic                  app_rdata_end,
    input  logic [DATA_WIDTH-1:0] app_rdata,
    output logic                  err
);
    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [5:0]            beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [5:0]            burst_q, burst_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cmd_en_q, cmd_en_d;
    logic                  wren_q, wren_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [5:0]            rbeat_cnt_q, rbeat_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [1:0]            rend_q, rend_d;
    logic                  err_q, err_d;
    logic [1:0]            elig;
    logic                  tag_push, tag_pop, tag_full, tag_empty;
    tag_t                  tag_in, tag_head;
    logic                  unused_rdata_end;

    // Beat counting against the tag is authoritative; the controller's end flag is ignored.
    assign unused_rdata_end = app_rdata_end;

    // A port whose grant pulse is on the wire this cycle may still show req high;
    // it is skipped so one transaction is never granted twice.
    assign elig[0] = init_calib_complete && p0_req && !gnt_q[0] && (p0_cmd == WR_CMD || !tag_full);
    assign elig[1] = init_calib_complete && p1_req && !gnt_q[1] && (p1_cmd == WR_CMD || !tag_full);

    assign tag_in = '{port: owner_q, burst: burst_q};

    ddr_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk   (clk_x1),
        .rst   (rst),
        .push  (tag_push),
        .din   (tag_in),
        .pop   (tag_pop),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        burst_d      = burst_q;
        wdata_d      = wdata_q;
        cmd_en_d     = 1'b0;
        wren_d       = 1'b0;
        gnt_d        = 2'b00;
        tag_push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    owner_d      = (elig == 2'b11) ? ~last_grant_q : elig[1];
                    last_grant_d = owner_d;
                    cmd_d        = owner_d ? p1_cmd   : p0_cmd;
                    addr_d       = owner_d ? p1_addr  : p0_addr;
                    burst_d      = owner_d ? p1_burst : p0_burst;
                    beat_cnt_d   = 6'd0;
                    state_d      = (cmd_d == WR_CMD) ? WDATA : CMD;
                end
            end
            WDATA: begin
                if (app_data_rdy) begin
                    wren_d     = 1'b1;
                    wdata_d    = owner_q ? p1_wdata : p0_wdata;
                    beat_cnt_d = beat_cnt_q + 6'd1;
                    if (beat_cnt_q == burst_q) begin
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                if (app_cmd_rdy) begin
                    cmd_en_d       = 1'b1;
                    gnt_d[owner_q] = 1'b1;
                    tag_push       = (cmd_q == RD_CMD);
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return path runs independently of the grant FSM.
    always_comb begin
        rvalid_d    = 2'b00;
        rend_d      = 2'b00;
        rdata_d     = rdata_q;
        rbeat_cnt_d = rbeat_cnt_q;
        err_d       = err_q;
        tag_pop     = 1'b0;
        if (app_rdata_valid) begin
            if (tag_empty) begin
                err_d = 1'b1;
            end else begin
                rdata_d                 = app_rdata;
                rvalid_d[tag_head.port] = 1'b1;
                if (rbeat_cnt_q == tag_head.burst) begin
                    rend_d[tag_head.port] = 1'b1;
                    tag_pop               = 1'b1;
                    rbeat_cnt_d           = 6'd0;
                end else begin
                    rbeat_cnt_d = rbeat_cnt_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            burst_q      <= '0;
            wdata_q      <= '0;
            cmd_en_q     <= 1'b0;
            wren_q       <= 1'b0;
            gnt_q        <= 2'b00;
            rbeat_cnt_q  <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 2'b00;
            rend_q       <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            burst_q      <= burst_d;
            wdata_q      <= wdata_d;
            cmd_en_q     <= cmd_en_d;
            wren_q       <= wren_d;
            gnt_q        <= gnt_d;
            rbeat_cnt_q  <= rbeat_cnt_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            rend_q       <= rend_d;
            err_q        <= err_d;
        end
    end

    assign p0_wdata_ack     = (state_q == WDATA) && !owner_q && app_data_rdy;
    assign p1_wdata_ack     = (state_q == WDATA) &&  owner_q && app_data_rdy;
    assign p0_gnt           = gnt_q[0];
    assign p1_gnt           = gnt_q[1];
    assign p0_rdata         = rdata_q;
    assign p1_rdata         = rdata_q;
    assign p0_rdata_valid   = rvalid_q[0];
    assign p1_rdata_valid   = rvalid_q[1];
    assign p0_rdata_end     = rend_q[0];
    assign p1_rdata_end     = rend_q[1];
    assign app_addr         = addr_q;
    assign app_cmd          = cmd_q;
    assign app_burst_number = burst_q;
    assign app_cmd_en       = cmd_en_q;
    assign app_wren         = wren_q;
    assign app_data_end     = wren_q;
    assign app_data         = wdata_q;
    assign err              = err_q;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// tb/tb_ddr_app_arbiter.sv - scoreboard testbench for ddr_app_arbiter
`timescale 1ns/1ps
module tb_ddr_app_arbiter;
    import ddr_app_pkg::*;

    localparam int AW = 27;
    localparam int DW = 128;

    logic          clk_x1 = 1'b0;
    logic          rst = 1'b1;
    logic          init_calib_complete = 1'b0;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic [2:0]    p0_cmd = '0, p1_cmd = '0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [5:0]    p0_burst = '0, p1_burst = '0;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_wdata_ack, p1_wdata_ack, p0_gnt, p1_gnt;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_rdata_valid, p1_rdata_valid, p0_rdata_end, p1_rdata_end;
    logic [AW-1:0] app_addr;
    logic          app_cmd_en, app_wren, app_data_end, err;
    logic [2:0]    app_cmd;
    logic [DW-1:0] app_data;
    logic [5:0]    app_burst_number;
    logic          app_cmd_rdy = 1'b1, app_data_rdy = 1'b1;
    logic          app_rdata_valid = 1'b0, app_rdata_end = 1'b0;
    logic [DW-1:0] app_rdata = '0;

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [5:0]    burst;
        int            port;
    } cmd_exp_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    cmd_exp_t      exp_c[$];
    rd_exp_t       exp_r[$];
    logic [DW-1:0] exp_w[$];

    int   n_checks = 0, n_fail = 0;
    int   act_cnt = 0, gnt0_cnt = 0;
    int   widx0 = 0, widx1 = 0;
    logic ack0_s, ack1_s;

    always #5 clk_x1 = ~clk_x1;

    function automatic logic [DW-1:0] wd(input int p, input int i);
        return {32'hC0DE_0000 + 32'(p), 64'h0, 32'(i)};
    endfunction

    assign p0_wdata = wd(0, widx0);
    assign p1_wdata = wd(1, widx1);

    ddr_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
        .clk_x1(clk_x1), .rst(rst), .init_calib_complete(init_calib_complete),
        .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_burst(p0_burst),
        .p0_wdata(p0_wdata), .p0_wdata_ack(p0_wdata_ack), .p0_gnt(p0_gnt),
        .p0_rdata(p0_rdata), .p0_rdata_valid(p0_rdata_valid), .p0_rdata_end(p0_rdata_end),
        .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_burst(p1_burst),
        .p1_wdata(p1_wdata), .p1_wdata_ack(p1_wdata_ack), .p1_gnt(p1_gnt),
        .p1_rdata(p1_rdata), .p1_rdata_valid(p1_rdata_valid), .p1_rdata_end(p1_rdata_end),
        .app_addr(app_addr), .app_cmd_en(app_cmd_en), .app_cmd(app_cmd),
        .app_cmd_rdy(app_cmd_rdy), .app_wren(app_wren), .app_data_end(app_data_end),
        .app_data(app_data), .app_data_rdy(app_data_rdy), .app_burst_number(app_burst_number),
        .app_rdata_valid(app_rdata_valid), .app_rdata_end(app_rdata_end),
        .app_rdata(app_rdata), .err(err)
    );

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred that the scoreboard did not expect", name);
    endfunction

    function automatic void exp_write(input int p, input logic [AW-1:0] addr, input logic [5:0] burst);
        cmd_exp_t c;
        c.cmd = WR_CMD; c.addr = addr; c.burst = burst; c.port = p;
        exp_c.push_back(c);
        for (int i = 0; i <= int'(burst); i++) begin
            exp_w.push_back(wd(p, ((p == 0) ? widx0 : widx1) + i));
        end
    endfunction

    function automatic void exp_read(input int p, input logic [AW-1:0] addr, input logic [5:0] burst);
        cmd_exp_t c;
        c.cmd = RD_CMD; c.addr = addr; c.burst = burst; c.port = p;
        exp_c.push_back(c);
    endfunction

    function automatic void exp_rbeat(input int p, input logic [DW-1:0] data, input logic last);
        rd_exp_t r;
        r.port = p; r.data = data; r.last = last;
        exp_r.push_back(r);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_x1);
            #1;
        end
    endtask

    // Holds req until the grant pulse is seen, then drops it after the next edge.
    task automatic request(input int p, input logic [2:0] cmd, input logic [AW-1:0] addr, input logic [5:0] burst);
        int   n = 0;
        logic g = 1'b0;
        if (p == 0) begin
            p0_cmd = cmd; p0_addr = addr; p0_burst = burst; p0_req = 1'b1;
        end else begin
            p1_cmd = cmd; p1_addr = addr; p1_burst = burst; p1_req = 1'b1;
        end
        while (!g && n < 400) begin
            @(negedge clk_x1);
            g = (p == 0) ? p0_gnt : p1_gnt;
            n++;
        end
        if (!g) note_fail($sformatf("gnt_timeout_p%0d", p));
        @(posedge clk_x1);
        #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic rdata_beats(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            app_rdata_valid = 1'b1;
            app_rdata = base + DW'(i);
            tick(1);
        end
        app_rdata_valid = 1'b0;
    endtask

    // Write-beat source: advance to the next beat after a cycle in which it was acknowledged.
    initial forever begin
        @(negedge clk_x1);
        ack0_s = p0_wdata_ack;
        ack1_s = p1_wdata_ack;
        @(posedge clk_x1);
        #1;
        if (ack0_s) widx0++;
        if (ack1_s) widx1++;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat, command or read beat.
    always @(negedge clk_x1) begin
        cmd_exp_t      ec;
        rd_exp_t       er;
        logic [DW-1:0] ew;
        if (!rst) begin
            if (app_wren) begin
                act_cnt++;
                if (exp_w.size() == 0) note_fail("wbeat_unexpected");
                else begin
                    ew = exp_w.pop_front();
                    chk("wbeat_data", app_data, ew);
                    chk("wbeat_end", DW'(app_data_end), DW'(1));
                end
            end
            if (app_cmd_en) begin
                act_cnt++;
                if (exp_c.size() == 0) note_fail("cmd_unexpected");
                else begin
                    ec = exp_c.pop_front();
                    chk("cmd_code", DW'(app_cmd), DW'(ec.cmd));
                    chk("cmd_addr", DW'(app_addr), DW'(ec.addr));
                    chk("cmd_burst", DW'(app_burst_number), DW'(ec.burst));
                    chk("cmd_gnt", DW'({p1_gnt, p0_gnt}), (ec.port == 0) ? DW'(1) : DW'(2));
                end
            end else if (p0_gnt || p1_gnt) begin
                note_fail("gnt_without_cmd");
            end
            if (p0_gnt) gnt0_cnt++;
            if (p0_rdata_valid || p1_rdata_valid) begin
                if (exp_r.size() == 0) note_fail("rbeat_unexpected");
                else begin
                    er = exp_r.pop_front();
                    chk("rd_port", DW'({p1_rdata_valid, p0_rdata_valid}), (er.port == 0) ? DW'(1) : DW'(2));
                    chk("rd_data", (er.port == 0) ? p0_rdata : p1_rdata, er.data);
                    chk("rd_end", DW'((er.port == 0) ? p0_rdata_end : p1_rdata_end), DW'(er.last));
                end
            end else if (p0_rdata_end || p1_rdata_end) begin
                note_fail("rend_without_valid");
            end
        end
    end

    initial begin
        int n;
        int g0;
        int a0;

        // Reset values
        tick(3);
        @(negedge clk_x1);
        chk("rst_cmd_en", DW'(app_cmd_en), DW'(0));
        chk("rst_wren", DW'({app_wren, app_data_end}), DW'(0));
        chk("rst_addr", DW'(app_addr), DW'(0));
        chk("rst_cmd_burst", DW'({app_cmd, app_burst_number}), DW'(0));
        chk("rst_data", app_data, DW'(0));
        chk("rst_gnt_rvalid", DW'({p1_gnt, p0_gnt, p1_rdata_valid, p0_rdata_valid, p1_rdata_end, p0_rdata_end}), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        @(posedge clk_x1);
        #1;
        rst = 1'b0;

        // Calibration gate, then p0 write burst 7 followed by p1 write burst 0
        exp_write(0, AW'('h100), 6'd7);
        exp_write(1, AW'('h180), 6'd0);
        fork
            request(0, WR_CMD, AW'('h100), 6'd7);
            request(1, WR_CMD, AW'('h180), 6'd0);
            begin
                tick(12);
                @(negedge clk_x1);
                #1;
                chk("calib_blocks_activity", DW'(act_cnt), DW'(0));
                chk("calib_no_ack", DW'({p1_wdata_ack, p0_wdata_ack}), DW'(0));
                init_calib_complete = 1'b1;
            end
        join
        tick(2);
        chk("p0_gnt_once", DW'(gnt0_cnt), DW'(1));

        // Both ports reading continuously: grants alternate starting with p0
        exp_read(0, AW'('h200), 6'd0);
        exp_read(1, AW'('h300), 6'd0);
        exp_read(0, AW'('h210), 6'd0);
        exp_read(1, AW'('h310), 6'd0);
        fork
            begin
                request(0, RD_CMD, AW'('h200), 6'd0);
                request(0, RD_CMD, AW'('h210), 6'd0);
            end
            begin
                request(1, RD_CMD, AW'('h300), 6'd0);
                request(1, RD_CMD, AW'('h310), 6'd0);
            end
        join
        exp_rbeat(0, DW'('hD0), 1'b1);
        exp_rbeat(1, DW'('hD1), 1'b1);
        exp_rbeat(0, DW'('hD2), 1'b1);
        exp_rbeat(1, DW'('hD3), 1'b1);
        rdata_beats(4, DW'('hD0));
        tick(3);

        // Multi-beat routing: p0 burst 1 then p1 burst 0
        exp_read(0, AW'('h400), 6'd1);
        exp_read(1, AW'('h500), 6'd0);
        request(0, RD_CMD, AW'('h400), 6'd1);
        request(1, RD_CMD, AW'('h500), 6'd0);
        exp_rbeat(0, DW'('hB1), 1'b0);
        exp_rbeat(0, DW'('hB2), 1'b1);
        exp_rbeat(1, DW'('hB3), 1'b1);
        rdata_beats(3, DW'('hB1));
        tick(3);

        // Tag FIFO full: fifth read waits, p1 write still served
        for (int i = 0; i < 4; i++) begin
            exp_read(0, AW'('h600 + 16 * i), 6'd0);
            request(0, RD_CMD, AW'('h600 + 16 * i), 6'd0);
        end
        exp_write(1, AW'('h700), 6'd0);
        exp_read(0, AW'('h640), 6'd0);
        g0 = gnt0_cnt;
        fork
            request(0, RD_CMD, AW'('h640), 6'd0);
            begin
                request(1, WR_CMD, AW'('h700), 6'd0);
                tick(8);
                chk("full_holds_read", DW'(gnt0_cnt), DW'(g0));
                exp_rbeat(0, DW'('hE0), 1'b1);
                rdata_beats(1, DW'('hE0));
            end
        join
        for (int i = 1; i <= 4; i++) exp_rbeat(0, DW'('hE0 + i), 1'b1);
        rdata_beats(4, DW'('hE1));
        tick(3);

        // Reset in the middle of a write burst, then a stray read beat
        for (int i = 0; i <= 3; i++) exp_w.push_back(wd(0, widx0 + i));
        a0 = act_cnt;
        p0_cmd = WR_CMD; p0_addr = AW'('h7F0); p0_burst = 6'd3; p0_req = 1'b1;
        n = 0;
        while (act_cnt == a0 && n < 50) begin
            @(negedge clk_x1);
            #1;
            n++;
        end
        chk("midburst_started", DW'(act_cnt != a0), DW'(1));
        @(posedge clk_x1);
        #1;
        rst = 1'b1;
        p0_req = 1'b0;
        @(negedge clk_x1);
        #1;
        chk("mid_rst_wren", DW'({app_wren, app_data_end, app_cmd_en}), DW'(0));
        chk("mid_rst_data", app_data, DW'(0));
        chk("mid_rst_addr_cmd", DW'({app_addr, app_cmd, app_burst_number}), DW'(0));
        chk("mid_rst_ack_gnt", DW'({p1_wdata_ack, p0_wdata_ack, p1_gnt, p0_gnt}), DW'(0));
        exp_w.delete();
        @(posedge clk_x1);
        #1;
        rst = 1'b0;
        tick(2);
        chk("err_before_stray", DW'(err), DW'(0));
        rdata_beats(1, DW'('hFF));
        @(negedge clk_x1);
        #1;
        chk("err_after_stray", DW'(err), DW'(1));
        chk("stray_dropped", DW'({p1_rdata_valid, p0_rdata_valid}), DW'(0));
        tick(3);
        chk("err_sticky", DW'(err), DW'(1));

        n = 0;
        while ((exp_w.size() + exp_c.size() + exp_r.size()) != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("scoreboard_drained", DW'(exp_w.size() + exp_c.size() + exp_r.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        note_fail("watchdog_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
